pipeadder: RTL and testbench

PIPEADDER -- requirements
Module: pipeadder

---
 rtl/pipeadder_if.sv | 35 +++
 rtl/pipeadder.sv | 113 +++++++++++
 tb/tb_pipeadder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeadder_if.sv
// Operand/result handshake bundle for pipeadder.
// The ci signal exists only when PIPEADDER_CI_EN is defined.
interface pipeadder_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  sub;
`ifdef PIPEADDER_CI_EN
    logic                  ci;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] sum;
    logic                  co;
    logic                  ov;

    modport master (
`ifdef PIPEADDER_CI_EN
        output ci,
`endif
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, co, ov
    );

    modport slave (
`ifdef PIPEADDER_CI_EN
        input  ci,
`endif
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, co, ov
    );
endinterface

// File: rtl/pipeadder.sv
// Segmented carry-chain adder/subtractor, one segment per pipeline stage.
// Optional carry/borrow-in port enabled by defining PIPEADDER_CI_EN.
module pipeadder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STAGES     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pipeadder_if.slave bus
);
    localparam int unsigned SEG = DATA_WIDTH / STAGES;

    logic                  en;
    logic                  cin;
    logic                  c0;
    logic [DATA_WIDTH-1:0] bx;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  co_q;
    logic                  ov_q;

    // Whole pipeline advances in lockstep; only the output slot can block it.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

`ifdef PIPEADDER_CI_EN
    assign cin = bus.ci;
`else
    assign cin = 1'b0;
`endif

    assign bx = bus.sub ? ~bus.b : bus.b;
    assign c0 = bus.sub ^ cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned InW = (STAGES - k) * SEG;

        logic [InW-1:0]       a_in;
        logic [InW-1:0]       b_in;
        logic                 c_in;
        logic                 v_in;
        logic [SEG-1:0]       s_seg;
        logic                 c_out;
        logic [(k+1)*SEG-1:0] s_all;

        assign {c_out, s_seg} = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                              + {{SEG{1'b0}}, c_in};

        if (k == 0) begin : g_src
            assign a_in  = bus.a;
            assign b_in  = bx;
            assign c_in  = c0;
            assign v_in  = bus.in_valid;
            assign s_all = s_seg;
        end else begin : g_src
            assign a_in  = g_stg[k-1].g_mid.a_q;
            assign b_in  = g_stg[k-1].g_mid.b_q;
            assign c_in  = g_stg[k-1].g_mid.c_q;
            assign v_in  = g_stg[k-1].g_mid.v_q;
            assign s_all = {s_seg, g_stg[k-1].g_mid.s_q};
        end

        if (k < STAGES - 1) begin : g_mid
            // Lower sum segments accumulate; unused upper operand segments shrink.
            logic                 v_q;
            logic                 c_q;
            logic [(k+1)*SEG-1:0] s_q;
            logic [InW-SEG-1:0]   a_q;
            logic [InW-SEG-1:0]   b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (en) begin
                    v_q <= v_in;
                end
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    c_q <= c_out;
                    s_q <= s_all;
                    a_q <= a_in[InW-1:SEG];
                    b_q <= b_in[InW-1:SEG];
                end
            end
        end else begin : g_last
            logic c_msb;

            // Carry into the MSB recovered from the MSB sum bit.
            assign c_msb = a_in[SEG-1] ^ b_in[SEG-1] ^ s_seg[SEG-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    co_q        <= 1'b0;
                    ov_q        <= 1'b0;
                end else if (en) begin
                    out_valid_q <= v_in;
                    sum_q       <= s_all;
                    co_q        <= c_out;
                    ov_q        <= c_msb ^ c_out;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.co        = co_q;
    assign bus.ov        = ov_q;
endmodule

// File: tb/tb_pipeadder.sv
// Self-checking bench for pipeadder (32-bit, 4 stages); exercises the ci
// path too when PIPEADDER_CI_EN is defined.
module tb_pipeadder;
    localparam int unsigned DW = 32;
    localparam int unsigned ST = 4;
`ifdef PIPEADDER_CI_EN
    localparam bit HAS_CI = 1'b1;
`else
    localparam bit HAS_CI = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sub;
        logic          ci;
        logic [DW-1:0] sum;
        logic          co;
        logic          ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    pipeadder_if #(.DATA_WIDTH(DW)) bus ();

    pipeadder #(.DATA_WIDTH(DW), .STAGES(ST)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    vec_t          vecs[$];
    vec_t          v;
    int            lat;
    int            sent;
    int            got;
    int            stale;
    logic [DW+1:0] res;
    logic [DW+1:0] held;
    logic          held_v;
    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] fexp[4];
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic          rs;
    logic          rc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Plain integer arithmetic: {sum, co, ov}.
    function automatic logic [DW+1:0] ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic s, input logic c);
        logic [DW-1:0] bx;
        logic          cin;
        logic          c0;
        logic [63:0]   u;
        longint        r;
        logic          ovf;
        cin = HAS_CI ? c : 1'b0;
        bx  = s ? ~b : b;
        c0  = s ? ~cin : cin;
        u   = 64'(a) + 64'(bx) + 64'(c0);
        r   = longint'($signed(a)) + longint'($signed(bx)) + longint'(c0);
        ovf = (r != longint'($signed(u[DW-1:0])));
        return {u[DW-1:0], u[DW], ovf};
    endfunction

    task automatic drive(input logic vld, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic s, input logic c);
        bus.in_valid = vld;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
`ifdef PIPEADDER_CI_EN
        bus.ci       = c;
`else
        if (c === 1'bx) bus.sub = s;
`endif
    endtask

    task automatic run_single(input vec_t tv, output int l, output logic [DW+1:0] r);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, tv.a, tv.b, tv.sub, tv.ci);
        l = 0;
        do begin
            @(negedge clk);
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            l++;
        end while (!bus.out_valid && l < 20);
        r = {bus.sum, bus.co, bus.ov};
    endtask

    initial begin
        vecs.push_back('{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h5,         32'h7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1});
        vecs.push_back('{32'hA,         32'h3, 1'b1, 1'b0, 32'h0000_0007, 1'b1, 1'b0});
        vecs.push_back('{32'h0,         32'h0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
`ifdef PIPEADDER_CI_EN
        vecs.push_back('{32'hA,         32'h3, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0});
        vecs.push_back('{32'hA,         32'h3, 1'b0, 1'b1, 32'h0000_000E, 1'b0, 1'b0});
`endif

        // Reset state
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(bus.out_valid), 64'(0));
        check("reset sum/co/ov", 64'({bus.sum, bus.co, bus.ov}), 64'(0));
        check("reset in_ready", 64'(bus.in_ready), 64'(1));
        rst_n = 1'b1;

        // Directed table: result and latency
        foreach (vecs[i]) begin
            v = vecs[i];
            run_single(v, lat, res);
            check("vector latency", 64'(lat), 64'(ST));
            check("vector result", 64'(res), 64'({v.sum, v.co, v.ov}));
        end

        // Random stream with random backpressure and bubbles
        sent   = 0;
        got    = 0;
        held_v = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            @(negedge clk);
            if (held_v) begin
                check("stall stable", 64'({bus.out_valid, bus.sum, bus.co, bus.ov}),
                      64'({1'b1, held}));
            end
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            drive((sent < 100) && ($urandom_range(0, 3) != 0), ra, rb, rs, rc);
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_add(ra, rb, rs, rc));
                sent++;
            end
            held_v = bus.out_valid && !bus.out_ready;
            held   = {bus.sum, bus.co, bus.ov};
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("stream extra beat", 64'(exp_q.size()), 64'(1));
                else check("stream result", 64'({bus.sum, bus.co, bus.ov}),
                           64'(exp_q.pop_front()));
                got++;
            end
        end
        check("stream beats out", 64'(got), 64'(100));
        check("stream queue empty", 64'(exp_q.size()), 64'(0));

        // Fill under full backpressure, then release
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            drive(1'b1, ra, rb, 1'(i & 1), 1'b0);
            fexp[i] = ref_add(ra, rb, 1'(i & 1), 1'b0);
            #1;
            check("fill in_ready", 64'(bus.in_ready), 64'(1));
            @(negedge clk);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        check("full in_ready", 64'(bus.in_ready), 64'(0));
        check("full out_valid", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            check("full held", 64'({bus.sum, bus.co, bus.ov}), 64'(fexp[0]));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain beat", 64'({bus.out_valid, bus.sum, bus.co, bus.ov}),
                  64'({1'b1, fexp[i]}));
            @(negedge clk);
        end
        check("drain done", 64'(bus.out_valid), 64'(0));

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i + 1), 32'h10, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("flight rst out_valid", 64'(bus.out_valid), 64'(0));
        check("flight rst sum", 64'(bus.sum), 64'(0));
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("no stale beat", 64'(stale), 64'(0));

        // Reset while a result is stalled at the output
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1234, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (ST + 1) @(negedge clk);
        check("pending out_valid", 64'(bus.out_valid), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("pending dropped", 64'(bus.out_valid), 64'(0));
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("pending no reappear", 64'(stale), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
